// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops memory writes for the tohost word, tracks run cycles,
// reports pass/fail/timeout per round and raises syscall pulses for
// non-terminating tohost writes. A round restarts on ack.
// Optional coverage-stall interrupt is built when TOHOST_MON_STALL_EN is defined.
module tohost_monitor #(
    parameter logic [63:0] TOHOST_ADDR    = 64'h8000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 20000000,
    parameter int unsigned STALL_CYCLES   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [63:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [29:0] cov,
    input  logic        ack,
    output logic [63:0] tohost,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        syscall,
    output logic [63:0] cycles,
    output logic        interrupt
);

    typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

    // Last run-cycle index before the watchdog forces completion.
    localparam logic [63:0] LP_TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
    // Value reported in tohost when the watchdog ends the round.
    localparam logic [63:0] LP_TIMEOUT_CODE = 64'h5;

    state_t      r_state;
    logic [63:0] r_tohost;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic        r_syscall;
    logic [63:0] r_cycles;

    logic        w_hit;
    logic        w_term;
    logic        w_sys;
    logic        w_expire;

    // Decode the snooped write beat and the watchdog expiry.
    always_comb begin
        w_hit    = wr_valid && (wr_addr == TOHOST_ADDR);
        w_term   = w_hit && wr_data[0];
        w_sys    = w_hit && !wr_data[0] && (wr_data != 64'd0);
        w_expire = (r_cycles == LP_TIMEOUT_LAST);
    end

    // Round FSM: RUN counts cycles and watches tohost, DONE freezes results until ack.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_tohost  <= 64'd0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_syscall <= 1'b0;
            r_cycles  <= 64'd0;
        end else begin
            r_syscall <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_term) begin
                        // A terminating write wins over a coincident watchdog expiry.
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_tohost  <= wr_data;
                        r_pass    <= (wr_data == 64'h1);
                        r_timeout <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_tohost  <= LP_TIMEOUT_CODE;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        if (r_cycles != '1) begin
                            r_cycles <= r_cycles + 64'd1;
                        end
                        if (w_sys) begin
                            r_tohost  <= wr_data;
                            r_syscall <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        r_state   <= ST_RUN;
                        r_done    <= 1'b0;
                        r_tohost  <= 64'd0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_cycles  <= 64'd0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign tohost  = r_tohost;
    assign done    = r_done;
    assign pass    = r_pass;
    assign timeout = r_timeout;
    assign syscall = r_syscall;
    assign cycles  = r_cycles;

`ifdef TOHOST_MON_STALL_EN
    logic [29:0] r_cov_prev;
    logic [63:0] r_stall;
    logic        r_interrupt;
    logic [63:0] w_stall_nxt;
    logic [63:0] w_thresh;

    // Next stall count and the cov-scaled threshold (full 64-bit product).
    always_comb begin
        w_thresh    = 64'(STALL_CYCLES) * (64'(cov >> 19) + 64'd1);
        w_stall_nxt = r_stall;
        if (r_state == ST_RUN) begin
            if (cov != r_cov_prev) begin
                w_stall_nxt = 64'd0;
            end else if (r_stall != '1) begin
                w_stall_nxt = r_stall + 64'd1;
            end
        end
    end

    // Stall counter and registered interrupt; cleared when a new round starts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cov_prev  <= 30'd0;
            r_stall     <= 64'd0;
            r_interrupt <= 1'b0;
        end else begin
            r_cov_prev <= cov;
            if ((r_state == ST_DONE) && ack) begin
                r_stall     <= 64'd0;
                r_interrupt <= 1'b0;
            end else begin
                r_stall     <= w_stall_nxt;
                r_interrupt <= (w_stall_nxt >= w_thresh);
            end
        end
    end

    assign interrupt = r_interrupt;
`else
    // Without stall logic cov has no consumer; fold it into a deliberately unused net.
    logic w_unused_cov;
    assign w_unused_cov = ^cov;
    assign interrupt    = 1'b0;
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed testbench for tohost_monitor: reset, pass/fail rounds, ack restart,
// syscall pulses, ignored writes, watchdog timeout, stall interrupt, reset in DONE.
module tb_tohost_monitor;

    localparam logic [63:0] ADDR = 64'h8000_1000;

    logic        clock = 1'b0;
    logic        reset, wr_valid, ack;
    logic [63:0] wr_addr, wr_data;
    logic [29:0] cov;
    logic [63:0] tohost, cycles;
    logic        done, pass, timeout, syscall, interrupt;

    logic        t_reset, t_wr_valid, t_ack;
    logic [63:0] t_wr_addr, t_wr_data;
    logic [29:0] t_cov;
    logic [63:0] t_tohost, t_cycles;
    logic        t_done, t_pass, t_timeout, t_syscall, t_interrupt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [62:0] fail_code;

    always #5 clock = ~clock;

    tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(1000), .STALL_CYCLES(10)) dut (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .cov(cov), .ack(ack), .tohost(tohost), .done(done),
        .pass(pass), .timeout(timeout), .syscall(syscall), .cycles(cycles),
        .interrupt(interrupt)
    );

    tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT_CYCLES(50), .STALL_CYCLES(10)) dut_t (
        .clock(clock), .reset(t_reset), .wr_valid(t_wr_valid), .wr_addr(t_wr_addr),
        .wr_data(t_wr_data), .cov(t_cov), .ack(t_ack), .tohost(t_tohost), .done(t_done),
        .pass(t_pass), .timeout(t_timeout), .syscall(t_syscall), .cycles(t_cycles),
        .interrupt(t_interrupt)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_addr  = 64'd0;
        wr_data  = 64'd0;
        ack      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h1; ack = 1'b1;
        step(); step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (tohost !== 64'd0) begin n_fail++; $display("FAIL reset_tohost: got %h want 0", tohost); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_cmp++; if (syscall !== 1'b0) begin n_fail++; $display("FAIL reset_syscall: got %b want 0", syscall); end
        n_cmp++; if (cycles !== 64'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_pass();
        repeat (100) step();
        n_cmp++; if (cycles !== 64'd100) begin n_fail++; $display("FAIL pass_cycles_before: got %0d want 100", cycles); end
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h1;
        step(); idle();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL pass_done: got %b want 1", done); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL pass_pass: got %b want 1", pass); end
        n_cmp++; if (tohost !== 64'h1) begin n_fail++; $display("FAIL pass_tohost: got %h want 1", tohost); end
        n_cmp++; if (cycles !== 64'd100) begin n_fail++; $display("FAIL pass_cycles: got %0d want 100", cycles); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL pass_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_ack_fail();
        ack = 1'b1;
        step(); idle();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ack_done: got %b want 0", done); end
        n_cmp++; if (cycles !== 64'd0) begin n_fail++; $display("FAIL ack_cycles: got %0d want 0", cycles); end
        n_cmp++; if (tohost !== 64'd0) begin n_fail++; $display("FAIL ack_tohost: got %h want 0", tohost); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL ack_pass: got %b want 0", pass); end
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h7;
        step(); idle();
        fail_code = tohost[63:1];
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL fail_done: got %b want 1", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL fail_pass: got %b want 0", pass); end
        n_cmp++; if (fail_code !== 63'd3) begin n_fail++; $display("FAIL fail_code: got %0d want 3", fail_code); end
        // Writes while DONE must be ignored.
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h1;
        step(); idle();
        n_cmp++; if (tohost !== 64'h7) begin n_fail++; $display("FAIL done_hold_tohost: got %h want 7", tohost); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL done_hold_pass: got %b want 0", pass); end
        n_cmp++; if (syscall !== 1'b0) begin n_fail++; $display("FAIL done_syscall: got %b want 0", syscall); end
        repeat (3) step();
        n_cmp++; if (cycles !== 64'd0) begin n_fail++; $display("FAIL done_cycles_frozen: got %0d want 0", cycles); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_level: got %b want 1", done); end
        ack = 1'b1;
        step(); idle();
    endtask

    task automatic test_syscall();
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h8000_2000;
        step(); idle();
        n_cmp++; if (syscall !== 1'b1) begin n_fail++; $display("FAIL sys_pulse: got %b want 1", syscall); end
        n_cmp++; if (tohost !== 64'h8000_2000) begin n_fail++; $display("FAIL sys_tohost: got %h want 80002000", tohost); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL sys_done: got %b want 0", done); end
        step();
        n_cmp++; if (syscall !== 1'b0) begin n_fail++; $display("FAIL sys_one_cycle: got %b want 0", syscall); end
        wr_valid = 1'b1; wr_addr = ADDR + 64'd8; wr_data = 64'h1;
        step(); idle();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL other_addr_done: got %b want 0", done); end
        n_cmp++; if (tohost !== 64'h8000_2000) begin n_fail++; $display("FAIL other_addr_tohost: got %h want 80002000", tohost); end
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h0;
        step(); idle();
        n_cmp++; if (tohost !== 64'h8000_2000) begin n_fail++; $display("FAIL zero_tohost: got %h want 80002000", tohost); end
        n_cmp++; if (syscall !== 1'b0) begin n_fail++; $display("FAIL zero_syscall: got %b want 0", syscall); end
        n_cmp++; if (cycles !== 64'd4) begin n_fail++; $display("FAIL sys_cycles: got %0d want 4", cycles); end
    endtask

    task automatic test_stall();
`ifdef TOHOST_MON_STALL_EN
        cov = 30'h80000;
        step();
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_start: got %b want 0", interrupt); end
        repeat (19) step();
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_19: got %b want 0", interrupt); end
        step();
        n_cmp++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL stall_20: got %b want 1", interrupt); end
        cov = 30'h80001;
        step();
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got %b want 0", interrupt); end
`else
        cov = 30'h80000;
        repeat (30) step();
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_off_held: got %b want 0", interrupt); end
        cov = 30'h3FFF_FFFF;
        step();
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_off_change: got %b want 0", interrupt); end
`endif
        cov = 30'd0;
    endtask

    task automatic test_reset_in_done();
        wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h3;
        step(); idle();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rid_enter_done: got %b want 1", done); end
        reset = 1'b0; wr_valid = 1'b1; wr_addr = ADDR; wr_data = 64'h1; ack = 1'b1;
        step();
        idle(); reset = 1'b1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rid_done: got %b want 0", done); end
        n_cmp++; if (tohost !== 64'd0) begin n_fail++; $display("FAIL rid_tohost: got %h want 0", tohost); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rid_pass: got %b want 0", pass); end
        n_cmp++; if (cycles !== 64'd0) begin n_fail++; $display("FAIL rid_cycles: got %0d want 0", cycles); end
        n_cmp++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL rid_interrupt: got %b want 0", interrupt); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rid_run_done: got %b want 0", done); end
        n_cmp++; if (cycles !== 64'd1) begin n_fail++; $display("FAIL rid_run_cycles: got %0d want 1", cycles); end
    endtask

    task automatic test_timeout();
        t_reset = 1'b1;
        repeat (49) step();
        n_cmp++; if (t_cycles !== 64'd49) begin n_fail++; $display("FAIL to_cycles49: got %0d want 49", t_cycles); end
        n_cmp++; if (t_done !== 1'b0) begin n_fail++; $display("FAIL to_early_done: got %b want 0", t_done); end
        step();
        n_cmp++; if (t_done !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b want 1", t_done); end
        n_cmp++; if (t_timeout !== 1'b1) begin n_fail++; $display("FAIL to_timeout: got %b want 1", t_timeout); end
        n_cmp++; if (t_tohost !== 64'h5) begin n_fail++; $display("FAIL to_tohost: got %h want 5", t_tohost); end
        n_cmp++; if (t_pass !== 1'b0) begin n_fail++; $display("FAIL to_pass: got %b want 0", t_pass); end
        t_ack = 1'b1;
        step();
        t_ack = 1'b0;
        n_cmp++; if (t_done !== 1'b0) begin n_fail++; $display("FAIL to_ack_done: got %b want 0", t_done); end
        n_cmp++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL to_ack_timeout: got %b want 0", t_timeout); end
        repeat (49) step();
        t_wr_valid = 1'b1; t_wr_addr = ADDR; t_wr_data = 64'h1;
        step();
        t_wr_valid = 1'b0; t_wr_data = 64'd0;
        n_cmp++; if (t_done !== 1'b1) begin n_fail++; $display("FAIL race_done: got %b want 1", t_done); end
        n_cmp++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL race_timeout: got %b want 0", t_timeout); end
        n_cmp++; if (t_pass !== 1'b1) begin n_fail++; $display("FAIL race_pass: got %b want 1", t_pass); end
        n_cmp++; if (t_tohost !== 64'h1) begin n_fail++; $display("FAIL race_tohost: got %h want 1", t_tohost); end
    endtask

    initial begin
        reset = 1'b0; cov = 30'd0;
        idle();
        t_reset = 1'b0; t_wr_valid = 1'b0; t_wr_addr = 64'd0; t_wr_data = 64'd0;
        t_cov = 30'd0; t_ack = 1'b0;
        test_reset();
        test_pass();
        test_ack_fail();
        test_syscall();
        test_stall();
        test_reset_in_done();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 64'h8000_1000: byte address of the tohost word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000000: run-cycle limit before forced completion.
REQ-003 SHALL have parameter STALL_CYCLES, default 1000: base coverage-stall window.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  1  snooped memory write beat valid.
REQ-007 SHALL have port wr_addr  input  64  write byte address.
REQ-008 SHALL have port wr_data  input  64  write data.
REQ-009 SHALL have port cov  input  30  running coverage sum from the DUT.
REQ-010 SHALL have port ack  input  1  testbench consumed result; starts next round.
REQ-011 SHALL have port tohost  output  64  latched tohost value.
REQ-012 SHALL have port done  output  1  round complete (level).
REQ-013 SHALL have port pass  output  1  round passed; valid while done.
REQ-014 SHALL have port timeout  output  1  round ended by watchdog; valid while done.
REQ-015 SHALL have port syscall  output  1  one-cycle pulse on non-terminating tohost write.
REQ-016 SHALL have port cycles  output  64  run cycles of current/last round.
REQ-017 SHALL have port interrupt  output  1  coverage-stall interrupt to core msip.

Function
REQ-018 SHALL implement FSM states RUN and DONE; the state after reset is RUN.
REQ-019 A hit is wr_valid && wr_addr==TOHOST_ADDR.
REQ-020 RUN: cycles increments by 1 each cycle and saturates at all-ones.
REQ-021 RUN: hit with wr_data[0]==1 loads tohost=wr_data, enters DONE; done asserts the cycle after the write beat.
REQ-022 On that entry, pass=1 iff wr_data==64'h1; otherwise pass=0 and the fail code is tohost[63:1].
REQ-023 RUN: hit with wr_data[0]==0 and wr_data!=0 loads tohost, pulses syscall one cycle, stays in RUN.
REQ-024 RUN: hit with wr_data==0 is ignored: no tohost update, no pulse.
REQ-025 RUN: when cycles reaches TIMEOUT_CYCLES-1 without a terminating hit, the next cycle enters DONE with timeout=1, pass=0, tohost=64'h5.
REQ-026 A terminating hit in the same cycle as timeout expiry wins: timeout=0.
REQ-027 DONE: done=1, tohost/pass/timeout/cycles frozen, hits ignored, syscall=0.
REQ-028 DONE with ack=1 returns to RUN next cycle with cycles, tohost, pass and timeout cleared to 0 and stall counters cleared; ack in RUN is ignored.
REQ-029 Stall counter: clears when cov differs from the value registered the previous cycle, else increments (saturating); it runs only in RUN.
REQ-030 interrupt=1 iff stall_count >= STALL_CYCLES*((cov>>19)+1); the product is computed at 64 bits with no overflow truncation.

Reset
REQ-031 With reset low at a posedge: state=RUN, tohost=0, done=0, pass=0, timeout=0, syscall=0, cycles=0, interrupt=0, stall counters=0.
REQ-032 Reset asserted mid-round or in DONE SHALL abandon the round; wr_valid and ack are ignored while reset is low.

Configuration
REQ-033 Macro TOHOST_MON_STALL_EN defined: the stall counter and interrupt are implemented per REQ-029/030.
REQ-034 Macro TOHOST_MON_STALL_EN undefined: no stall logic, interrupt tied to 0, cov unused; all other behaviour is unchanged.

Verification
REQ-035 Write 64'h1 to TOHOST_ADDR at run-cycle 100 -> next cycle done=1, pass=1, tohost=1, cycles=100.
REQ-036 Write 64'h7 -> done=1, pass=0, tohost[63:1]=3; ack pulse -> next cycle done=0, cycles=0, tohost=0.
REQ-037 TIMEOUT_CYCLES=50, no writes -> done=1, timeout=1, tohost=5 after 50 cycles; a terminating write on the expiry cycle -> timeout=0.
REQ-038 Write 64'h80002000 -> syscall high exactly 1 cycle, done stays 0; write to TOHOST_ADDR+8 -> no effect.
REQ-039 TOHOST_MON_STALL_EN defined, STALL_CYCLES=10, cov held at 30'h80000 -> interrupt rises after 20 stall cycles; a cov change -> interrupt clears next cycle; macro undefined -> interrupt stays 0.
REQ-040 Reset low for one cycle while in DONE -> state RUN, all outputs 0 the following cycle.
